mfm_sector_sequencer: RTL



---
 rtl/mfm_pkg.sv | 43 ++++
 rtl/mfm_crc16.sv | 36 +++
 rtl/mfm_sector_sequencer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mfm_pkg.sv
// mfm_pkg: shared MFM constants, state/status encodings and the CRC-CCITT byte step
// used by the sector sequencer and its optional CRC checker.
package mfm_pkg;

    localparam logic [15:0] SYNC_MFM = 16'h4489;
    localparam logic [7:0]  IDAM     = 8'hFE;
    localparam logic [7:0]  DAM      = 8'hF8;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;
    localparam logic [15:0] CRC_POLY = 16'h1021;

    typedef enum logic [2:0] {
        ST_OK           = 3'd0,
        ST_ID_TIMEOUT   = 3'd1,
        ST_ID_CRC       = 3'd2,
        ST_DATA_TIMEOUT = 3'd3,
        ST_DATA_CRC     = 3'd4,
        ST_BAD_MARK     = 3'd5,
        ST_ABORTED      = 3'd6
    } status_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HUNT_ID,
        S_READ_ID,
        S_HUNT_DATA,
        S_READ_DATA,
        S_FINISH
    } state_e;

    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            c = {c[14:0], 1'b0} ^ ((c[15] ^ data[i]) ? CRC_POLY : 16'h0000);
        end
        return c;
    endfunction

    // The three A1 sync bytes never reach byte_buffer as framed data, so they are folded into the preset.
    localparam logic [15:0] CRC_SYNC_PRESET =
        crc16_byte(crc16_byte(crc16_byte(CRC_INIT, 8'hA1), 8'hA1), 8'hA1);

endpackage

// File: rtl/mfm_crc16.sv
// mfm_crc16: byte-serial CRC-CCITT over a framed MFM field; flags a zero residue
// for the running CRC after the byte currently on data_i is absorbed.
module mfm_crc16
    import mfm_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clear_i,
    input  logic       enable_i,
    input  logic [7:0] data_i,
    output logic       residue_zero_o
);

    logic [15:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clear_i) begin
            crc_d = CRC_SYNC_PRESET;
        end else if (enable_i) begin
            crc_d = crc16_byte(crc_q, data_i);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            crc_q <= CRC_SYNC_PRESET;
        end else begin
            crc_q <= crc_d;
        end
    end

    // Look-ahead so the sequencer can decide on the same cycle it samples the last CRC byte.
    assign residue_zero_o = (crc16_byte(crc_q, data_i) == 16'h0000);

endmodule

// File: rtl/mfm_sector_sequencer.sv
// mfm_sector_sequencer: hunts the A1 sync, matches the ID field, streams the data field.
// Build option MFM_CRC_CHECK_EN adds CRC verification of ID and data fields.
module mfm_sector_sequencer
    import mfm_pkg::*;
#(
    parameter int SECTOR_BYTES     = 512,
    parameter int ID_TIMEOUT_CELLS = 200000,
    parameter int DATA_GAP_CELLS   = 1024
) (
    input  logic        clk_5,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [9:0]  target_cyl,
    input  logic [2:0]  target_head,
    input  logic [7:0]  target_sector,
    input  logic [15:0] mfm_buffer,
    input  logic [7:0]  byte_buffer,
    output logic        busy,
    output logic        done,
    output logic [2:0]  status,
    output logic [7:0]  data_out,
    output logic        data_valid
);

    localparam int IDT_W = $clog2(ID_TIMEOUT_CELLS);
    localparam int GAP_W = $clog2(DATA_GAP_CELLS);
    localparam int IDX_W = ($clog2(SECTOR_BYTES + 3) > 3) ? $clog2(SECTOR_BYTES + 3) : 3;

    localparam logic [IDT_W-1:0] ID_LAST        = IDT_W'(ID_TIMEOUT_CELLS - 1);
    localparam logic [GAP_W-1:0] GAP_LAST       = GAP_W'(DATA_GAP_CELLS - 1);
    localparam logic [IDX_W-1:0] ID_LAST_BYTE   = IDX_W'(5);
    localparam logic [IDX_W-1:0] DATA_LAST_BYTE = IDX_W'(SECTOR_BYTES + 2);

    state_e           state_q, state_d;
    status_e          status_q, status_d;
    logic [IDT_W-1:0] id_timer_q, id_timer_d;
    logic [GAP_W-1:0] gap_timer_q, gap_timer_d;
    logic [3:0]       phase_q, phase_d;
    logic [IDX_W-1:0] byte_idx_q, byte_idx_d;
    logic             id_match_q, id_match_d;
    logic [7:0]       data_out_q, data_out_d;
    logic             data_valid_q, data_valid_d;

    logic sample;
    logic sync_seen;
    logic crc_ok;

    assign sample    = (phase_q == 4'hF);
    assign sync_seen = (mfm_buffer == SYNC_MFM);

`ifdef MFM_CRC_CHECK_EN
    logic crc_clear;
    logic crc_enable;

    assign crc_clear  = (state_q == S_HUNT_ID) || (state_q == S_HUNT_DATA);
    assign crc_enable = sample && ((state_q == S_READ_ID) || (state_q == S_READ_DATA));

    mfm_crc16 u_crc (
        .clk_i          (clk_5),
        .rst_i          (reset),
        .clear_i        (crc_clear),
        .enable_i       (crc_enable),
        .data_i         (byte_buffer),
        .residue_zero_o (crc_ok)
    );
`else
    assign crc_ok = 1'b1;
`endif

    always_comb begin
        // NOTE: every _d gets its hold value first, so no path through the case can infer a latch.
        state_d      = state_q;
        status_d     = status_q;
        id_timer_d   = id_timer_q;
        gap_timer_d  = gap_timer_q;
        phase_d      = phase_q + 4'd1;
        byte_idx_d   = byte_idx_q;
        id_match_d   = id_match_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_HUNT_ID;
                    id_timer_d = '0;
                end
            end
            S_HUNT_ID: begin
                id_timer_d = (id_timer_q == ID_LAST) ? id_timer_q : id_timer_q + IDT_W'(1);
                if (sync_seen) begin
                    state_d    = S_READ_ID;
                    phase_d    = '0;
                    byte_idx_d = '0;
                    id_match_d = 1'b1;
                end else if (id_timer_q == ID_LAST) begin
                    state_d  = S_FINISH;
                    status_d = ST_ID_TIMEOUT;
                end
            end
            S_READ_ID: begin
                if (sample) begin
                    byte_idx_d = byte_idx_q + IDX_W'(1);
                    if (byte_idx_q == IDX_W'(0) && byte_buffer != IDAM) begin
                        state_d = S_HUNT_ID;
                    end else if (byte_idx_q == IDX_W'(1)) begin
                        id_match_d = id_match_q & (byte_buffer == target_cyl[7:0]);
                    end else if (byte_idx_q == IDX_W'(2)) begin
                        id_match_d = id_match_q &
                                     (byte_buffer == {target_cyl[9:8], 3'b000, target_head});
                    end else if (byte_idx_q == IDX_W'(3)) begin
                        id_match_d = id_match_q & (byte_buffer == target_sector);
                    end else if (byte_idx_q == ID_LAST_BYTE) begin
                        if (!crc_ok) begin
                            state_d  = S_FINISH;
                            status_d = ST_ID_CRC;
                        end else if (!id_match_q) begin
                            state_d = S_HUNT_ID;
                        end else begin
                            state_d     = S_HUNT_DATA;
                            gap_timer_d = '0;
                        end
                    end
                end
            end
            S_HUNT_DATA: begin
                gap_timer_d = (gap_timer_q == GAP_LAST) ? gap_timer_q : gap_timer_q + GAP_W'(1);
                if (sync_seen) begin
                    state_d    = S_READ_DATA;
                    phase_d    = '0;
                    byte_idx_d = '0;
                end else if (gap_timer_q == GAP_LAST) begin
                    state_d  = S_FINISH;
                    status_d = ST_DATA_TIMEOUT;
                end
            end
            S_READ_DATA: begin
                if (sample) begin
                    byte_idx_d = byte_idx_q + IDX_W'(1);
                    if (byte_idx_q == IDX_W'(0)) begin
                        if (byte_buffer != DAM) begin
                            state_d  = S_FINISH;
                            status_d = ST_BAD_MARK;
                        end
                    end else if (byte_idx_q <= IDX_W'(SECTOR_BYTES)) begin
                        data_out_d   = byte_buffer;
                        data_valid_d = 1'b1;
                    end else if (byte_idx_q == DATA_LAST_BYTE) begin
                        state_d  = S_FINISH;
                        status_d = crc_ok ? ST_OK : ST_DATA_CRC;
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides whatever the active state decided this cycle, including a payload strobe.
        if (abort && state_q != S_IDLE && state_q != S_FINISH) begin
            state_d      = S_FINISH;
            status_d     = ST_ABORTED;
            data_out_d   = data_out_q;
            data_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_5 or posedge reset) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (reset) begin
            state_q      <= S_IDLE;
            status_q     <= ST_OK;
            id_timer_q   <= '0;
            gap_timer_q  <= '0;
            phase_q      <= '0;
            byte_idx_q   <= '0;
            id_match_q   <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            status_q     <= status_d;
            id_timer_q   <= id_timer_d;
            gap_timer_q  <= gap_timer_d;
            phase_q      <= phase_d;
            byte_idx_q   <= byte_idx_d;
            id_match_q   <= id_match_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
        end
    end

    assign busy       = (state_q != S_IDLE) && (state_q != S_FINISH);
    assign done       = (state_q == S_FINISH);
    assign status     = status_q;
    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;

endmodule
